// File: rtl/cpu_pkg.sv
// Shared encodings for the fetch/data addressing unit.
// RAM command codes and the bus arbiter state type.
package cpu_pkg;

    typedef logic [1:0] mem_cmd_t;

    localparam mem_cmd_t MNONE  = 2'b00;
    localparam mem_cmd_t MREAD  = 2'b01;
    localparam mem_cmd_t MWRITE = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DATA
    } state_t;

endpackage

// File: rtl/fetch_addr_unit_if.sv
// Bundle of RAM, instruction-register, redirect and data-access signals.
// master is the addressing unit; slave is its surroundings.
interface fetch_addr_unit_if #(
    parameter int AW = 9,
    parameter int DW = 16
);

    logic [AW-1:0] mem_addr;
    logic [1:0]    mem_cmd;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;

    logic          ir_valid;
    logic [DW-1:0] ir_data;
    logic [AW-1:0] ir_pc;
    logic          ir_ready;

    logic          redirect;
    logic          redir_sel;
    logic [AW-1:0] rel;
    logic [AW-1:0] abs_tgt;
    logic [AW-1:0] link_pc;

    logic          dreq_valid;
    logic          dreq_write;
    logic [AW-1:0] dreq_addr;
    logic [DW-1:0] dreq_wdata;
    logic          dreq_ready;
    logic          drsp_valid;
    logic [DW-1:0] drsp_data;

    modport master (
        output mem_addr, mem_cmd, mem_wdata,
        input  mem_rdata, mem_ready,
        output ir_valid, ir_data, ir_pc,
        input  ir_ready,
        input  redirect, redir_sel, rel, abs_tgt,
        output link_pc,
        input  dreq_valid, dreq_write, dreq_addr, dreq_wdata,
        output dreq_ready, drsp_valid, drsp_data
    );

    modport slave (
        input  mem_addr, mem_cmd, mem_wdata,
        output mem_rdata, mem_ready,
        input  ir_valid, ir_data, ir_pc,
        output ir_ready,
        output redirect, redir_sel, rel, abs_tgt,
        input  link_pc,
        output dreq_valid, dreq_write, dreq_addr, dreq_wdata,
        input  dreq_ready, drsp_valid, drsp_data
    );

endinterface

// File: rtl/fetch_queue.sv
// Prefetch FIFO holding {pc, instruction} pairs, with flush.
// A push into a full queue is accepted only alongside a pop.
module fetch_queue #(
    parameter int W     = 25,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= bump(wr_ptr);
            if (do_pop)  rd_ptr <= bump(rd_ptr);
            if (do_push && !do_pop)
                count <= count + CW'(1);
            else if (do_pop && !do_push)
                count <= count - CW'(1);
        end
    end

endmodule

// File: rtl/fetch_addr_unit.sv
// Program counter, prefetch queue and single-port RAM arbiter.
// Data accesses beat prefetch; one RAM command outstanding at a time.
module fetch_addr_unit
    import cpu_pkg::*;
#(
    parameter int            AW       = 9,
    parameter int            DW       = 16,
    parameter int            QDEPTH   = 2,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input logic               clk,
    input logic               reset,
    fetch_addr_unit_if.master bus
);

    localparam int            EW     = AW + DW;
    localparam logic [AW-1:0] PC_ONE = AW'(1);

    state_t        state_q;
    state_t        state_d;
    logic [AW-1:0] pc_q;
    logic [AW-1:0] addr_q;
    mem_cmd_t      cmd_q;
    logic [DW-1:0] wdata_q;
    logic          epoch_q;
    logic          req_epoch_q;

    logic          issue_data;
    logic          issue_fetch;
    logic          fetch_done;
    logic          data_done;
    logic          accept;

    logic          q_full;
    logic          q_empty;
    logic          q_push;
    logic          q_pop;
    logic [EW-1:0] q_head;
    logic [AW-1:0] head_pc;
    logic [DW-1:0] head_data;
    logic [AW-1:0] target;

    fetch_queue #(
        .W     (EW),
        .DEPTH (QDEPTH)
    ) u_queue (
        .clk       (clk),
        .reset     (reset),
        .flush     (bus.redirect),
        .push      (q_push),
        .push_data ({addr_q, bus.mem_rdata}),
        .pop       (q_pop),
        .head      (q_head),
        .full      (q_full),
        .empty     (q_empty)
    );

    assign {head_pc, head_data} = q_head;

    assign bus.ir_valid = !q_empty;
    assign bus.ir_data  = head_data;
    assign bus.ir_pc    = head_pc;
    assign bus.link_pc  = head_pc + PC_ONE;

    assign target = bus.redir_sel ? bus.abs_tgt
                                  : head_pc + PC_ONE + bus.rel;

    // A fetch launched before the last redirect carries a stale epoch
    assign q_push = fetch_done && (req_epoch_q == epoch_q)
                    && !bus.redirect;
    assign q_pop  = !q_empty && bus.ir_ready && !bus.redirect;

    assign bus.mem_addr   = addr_q;
    assign bus.mem_cmd    = cmd_q;
    assign bus.mem_wdata  = wdata_q;
    assign bus.dreq_ready = accept;
    assign bus.drsp_valid = data_done;
    assign bus.drsp_data  = bus.mem_rdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (issue_data)       state_d = DATA;
                else if (issue_fetch) state_d = FETCH;
            end
            FETCH:   if (bus.mem_ready) state_d = IDLE;
            DATA:    if (bus.mem_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        issue_data  = 1'b0;
        issue_fetch = 1'b0;
        fetch_done  = 1'b0;
        data_done   = 1'b0;
        accept      = 1'b0;
        unique case (state_q)
            IDLE: begin
                issue_data  = bus.dreq_valid && reset;
                accept      = issue_data;
                issue_fetch = !bus.dreq_valid && !q_full
                              && !bus.redirect;
            end
            FETCH:   fetch_done = bus.mem_ready;
            DATA:    data_done  = bus.mem_ready;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q      <= '0;
            cmd_q       <= MNONE;
            wdata_q     <= '0;
            req_epoch_q <= 1'b0;
        end else if (issue_data) begin
            addr_q  <= bus.dreq_addr;
            cmd_q   <= bus.dreq_write ? MWRITE : MREAD;
            wdata_q <= bus.dreq_wdata;
        end else if (issue_fetch) begin
            addr_q      <= pc_q;
            cmd_q       <= MREAD;
            req_epoch_q <= epoch_q;
        end else if (fetch_done || data_done) begin
            cmd_q <= MNONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q    <= RESET_PC;
            epoch_q <= 1'b0;
        end else if (bus.redirect) begin
            pc_q    <= target;
            epoch_q <= ~epoch_q;
        end else if (q_push) begin
            pc_q <= pc_q + PC_ONE;
        end
    end

endmodule

// File: tb/tb_fetch_addr_unit.sv
// Directed bench for fetch_addr_unit with queued expectations
// checked by a negedge monitor against bus, IR and data responses.
module tb_fetch_addr_unit;
    import cpu_pkg::*;

    localparam int AW = 9;
    localparam int DW = 16;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    fetch_addr_unit_if #(.AW(AW), .DW(DW)) bus ();

    fetch_addr_unit #(
        .AW       (AW),
        .DW       (DW),
        .QDEPTH   (2),
        .RESET_PC (9'h000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [1:0]    cmd;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } bus_t;

    typedef struct {
        logic [AW-1:0] pc;
        logic [DW-1:0] data;
    } ir_t;

    typedef struct {
        bit            load;
        logic [DW-1:0] data;
    } rsp_t;

    bus_t exp_bus[$];
    ir_t  exp_ir[$];
    rsp_t exp_rsp[$];

    int errors = 0;
    int checks = 0;
    int lat    = 0;
    bit bus_strict = 1'b1;

    function automatic logic [DW-1:0] word(input logic [AW-1:0] a);
        return 16'hA000 ^ {7'd0, a};
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_redirect(input bit sel, input logic [AW-1:0] r,
                               input logic [AW-1:0] a);
        bus.redirect  = 1'b1;
        bus.redir_sel = sel;
        bus.rel       = r;
        bus.abs_tgt   = a;
        tick(1);
        bus.redirect  = 1'b0;
    endtask

    task automatic data_req(input bit wr, input logic [AW-1:0] a,
                            input logic [DW-1:0] d);
        int n;
        bus.dreq_valid = 1'b1;
        bus.dreq_write = wr;
        bus.dreq_addr  = a;
        bus.dreq_wdata = d;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.dreq_ready && n < 50);
        chk("dreq_ready", bus.dreq_ready, 1);
        tick(1);
        bus.dreq_valid = 1'b0;
    endtask

    assign bus.mem_rdata = word(bus.mem_addr);

    // RAM model: answers after lat wait cycles
    initial begin
        int cnt;
        cnt = 0;
        bus.mem_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.mem_cmd != MNONE) begin
                bus.mem_ready = (cnt >= lat);
                cnt = bus.mem_ready ? 0 : cnt + 1;
            end else begin
                bus.mem_ready = 1'b0;
                cnt = 0;
            end
        end
    end

    initial begin
        bus_t eb;
        ir_t  ei;
        rsp_t er;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (bus.mem_cmd != MNONE && bus.mem_ready) begin
                    if (exp_bus.size() > 0) begin
                        eb = exp_bus.pop_front();
                        chk("bus_cmd", bus.mem_cmd, eb.cmd);
                        chk("bus_addr", bus.mem_addr, eb.addr);
                        if (eb.cmd == MWRITE)
                            chk("bus_wdata", bus.mem_wdata, eb.wdata);
                    end else if (bus_strict) begin
                        fail("bus_unexpected");
                    end
                end
                if (bus.ir_valid && bus.ir_ready && !bus.redirect) begin
                    if (exp_ir.size() > 0) begin
                        ei = exp_ir.pop_front();
                        chk("ir_pc", bus.ir_pc, ei.pc);
                        chk("ir_data", bus.ir_data, ei.data);
                    end else begin
                        fail("ir_unexpected");
                    end
                end
                if (bus.drsp_valid) begin
                    if (exp_rsp.size() > 0) begin
                        er = exp_rsp.pop_front();
                        if (er.load)
                            chk("drsp_data", bus.drsp_data, er.data);
                    end else begin
                        fail("drsp_unexpected");
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int pops;
        bus.ir_ready   = 1'b0;
        bus.redirect   = 1'b0;
        bus.redir_sel  = 1'b0;
        bus.rel        = '0;
        bus.abs_tgt    = '0;
        bus.dreq_valid = 1'b1;
        bus.dreq_write = 1'b0;
        bus.dreq_addr  = '0;
        bus.dreq_wdata = '0;

        // reset state
        #12;
        chk("rst_cmd", bus.mem_cmd, MNONE);
        chk("rst_ir_valid", bus.ir_valid, 0);
        chk("rst_dreq_ready", bus.dreq_ready, 0);
        chk("rst_drsp_valid", bus.drsp_valid, 0);
        bus.dreq_valid = 1'b0;

        // 1: fill the queue from RESET_PC
        exp_bus.push_back('{MREAD, 9'h000, 16'h0});
        exp_bus.push_back('{MREAD, 9'h001, 16'h0});
        tick(1);
        reset = 1'b1;
        tick(8);
        @(negedge clk);
        chk("t1_full_idle", bus.mem_cmd, MNONE);
        chk("t1_ir_valid", bus.ir_valid, 1);
        chk("t1_ir_pc", bus.ir_pc, 9'h000);
        chk("t1_ir_data", bus.ir_data, word(9'h000));
        chk("t1_link", bus.link_pc, 9'h001);

        // 2: slow RAM, command held until ready
        lat = 3;
        exp_ir.push_back('{9'h000, word(9'h000)});
        exp_bus.push_back('{MREAD, 9'h002, 16'h0});
        tick(1);
        bus.ir_ready = 1'b1;
        tick(1);
        bus.ir_ready = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.mem_cmd != MREAD && n < 20);
        if (bus.mem_cmd != MREAD) fail("t2_issue_timeout");
        for (int k = 0; k < 3; k++) begin
            chk("t2_hold_cmd", bus.mem_cmd, MREAD);
            chk("t2_hold_addr", bus.mem_addr, 9'h002);
            chk("t2_wait", bus.mem_ready, 0);
            @(negedge clk);
        end
        chk("t2_done", bus.mem_ready, 1);
        tick(4);
        @(negedge clk);
        chk("t2_full_idle", bus.mem_cmd, MNONE);
        chk("t2_head", bus.ir_pc, 9'h001);

        // 3: relative redirect while a fetch is in flight
        tick(1);
        exp_bus.push_back('{MREAD, 9'h005, 16'h0});
        exp_bus.push_back('{MREAD, 9'h006, 16'h0});
        exp_bus.push_back('{MREAD, 9'h003, 16'h0});
        exp_bus.push_back('{MREAD, 9'h004, 16'h0});
        do_redirect(1'b1, 9'h000, 9'h005);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(bus.ir_valid && bus.ir_pc == 9'h005
                     && bus.mem_cmd == MREAD
                     && bus.mem_addr == 9'h006) && n < 60);
        if (n >= 60) fail("t3_setup_timeout");
        tick(1);
        do_redirect(1'b0, 9'h1FD, 9'h000);
        @(negedge clk);
        chk("t3_flushed", bus.ir_valid, 0);
        chk("t3_inflight_cmd", bus.mem_cmd, MREAD);
        chk("t3_inflight_addr", bus.mem_addr, 9'h006);
        n = 0;
        while (!bus.ir_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("t3_head_pc", bus.ir_pc, 9'h003);
        chk("t3_head_data", bus.ir_data, word(9'h003));
        tick(20);

        // 4: absolute redirect to the top of memory, consuming
        lat = 0;
        bus_strict = 1'b0;
        exp_bus.push_back('{MREAD, 9'h1FF, 16'h0});
        exp_bus.push_back('{MREAD, 9'h000, 16'h0});
        exp_bus.push_back('{MREAD, 9'h001, 16'h0});
        exp_ir.push_back('{9'h1FF, word(9'h1FF)});
        exp_ir.push_back('{9'h000, word(9'h000)});
        exp_ir.push_back('{9'h001, word(9'h001)});
        bus.ir_ready = 1'b1;
        do_redirect(1'b1, 9'h000, 9'h1FF);
        pops = 0;
        n = 0;
        while (pops < 3 && n < 60) begin
            @(negedge clk);
            n++;
            if (bus.ir_valid && bus.ir_ready && !bus.redirect) begin
                pops++;
                if (bus.ir_pc == 9'h1FF)
                    chk("t4_link_wrap", bus.link_pc, 9'h000);
            end
        end
        if (pops < 3) fail("t4_pop_timeout");
        tick(1);
        bus.ir_ready = 1'b0;
        tick(10);
        bus_strict = 1'b1;
        chk("t4_bus_drained", exp_bus.size(), 0);

        // 5: data access beats prefetch
        lat = 1;
        exp_bus.push_back('{MWRITE, 9'h010, 16'hBEEF});
        exp_bus.push_back('{MREAD, 9'h040, 16'h0});
        exp_bus.push_back('{MREAD, 9'h041, 16'h0});
        exp_rsp.push_back('{1'b0, 16'h0});
        do_redirect(1'b1, 9'h000, 9'h040);
        data_req(1'b1, 9'h010, 16'hBEEF);
        tick(15);
        exp_bus.push_back('{MREAD, 9'h022, 16'h0});
        exp_rsp.push_back('{1'b1, word(9'h022)});
        data_req(1'b0, 9'h022, 16'h0);
        tick(8);
        chk("t5_rsp_drained", exp_rsp.size(), 0);

        // 6: asynchronous reset during a fetch
        lat = 3;
        do_redirect(1'b1, 9'h000, 9'h080);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(bus.mem_cmd == MREAD && bus.mem_addr == 9'h080)
                   && n < 30);
        if (n >= 30) fail("t6_setup_timeout");
        #1;
        reset = 1'b0;
        #1;
        chk("t6_async_cmd", bus.mem_cmd, MNONE);
        chk("t6_async_ir", bus.ir_valid, 0);
        exp_bus.push_back('{MREAD, 9'h000, 16'h0});
        exp_bus.push_back('{MREAD, 9'h001, 16'h0});
        tick(2);
        reset = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.mem_cmd == MNONE && n < 20);
        chk("t6_first_addr", bus.mem_addr, 9'h000);
        tick(25);

        chk("end_bus_drained", exp_bus.size(), 0);
        chk("end_ir_drained", exp_ir.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
